sysbus_mem_responder: RTL and testbench
=======================================

Name: sysbus_mem_responder

Overview:
- Responder (memory side) of the Sysbus request/response protocol.
- Accepts line-sized read and write requests from an initiator such as the fetch/core unit and serves them from an internal word-addressed backing store.
- Returns read lines as LINE_BEATS sequential 64-bit response beats.
- Used as the simulation/FPGA memory model behind the core.

Parameters:
- DATA_WIDTH, 64, width of req/resp data beats.
- TAG_WIDTH, 13, tag width: bit 12 = R/W (READ=1, WRITE=0), bits 11:8 = type (MEMORY=4'h1, MMIO=4'h0), bits 7:0 = id.
- LINE_BEATS, 8, beats per line (64-byte line).
- MEM_WORDS, 4096, backing-store depth in 64-bit words; power of two.
- READ_LATENCY, 4, idle cycles between read accept and first response beat; minimum 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; the block is in reset on any posedge where reset==0.
- reqcyc  in  1  initiator drives a valid request/write-data beat.
- req  in  DATA_WIDTH  address on the header beat; write data on subsequent beats.
- reqtag  in  TAG_WIDTH  request tag, sampled on the header beat only.
- reqack  out  1  beat accepted this cycle.
- respcyc  out  1  response beat valid.
- resp  out  DATA_WIDTH  response data.
- resptag  out  TAG_WIDTH  echo of the accepted request tag.
- respack  in  1  initiator consumes the response beat this cycle.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; respcyc=0, resp=0, resptag=0, beat and latency counters=0. Backing-store contents are not cleared.
- reqack is combinational: reqack = reqcyc && (state==IDLE || state==WDATA). A transfer occurs on a cycle where reqcyc && reqack.
- The initiator holds req/reqtag stable while reqcyc=1 and reqack=0.
- Address handling: base word = req[63:6] * LINE_BEATS. Low 6 bits are ignored (forced line alignment). Word index is taken modulo MEM_WORDS (silent wrap, no error).
- Type field is not decoded: MMIO and MEMORY requests are both served from the store.
- IDLE:
  - Header transfer with R/W=READ: latch base and tag, load the latency counter with READ_LATENCY, go to RWAIT.
  - Header transfer with R/W=WRITE: latch base and tag, beat=0, go to WDATA.
- WDATA:
  - Each transfer writes req to store[base+beat] and increments beat.
  - The transfer with beat==LINE_BEATS-1 goes to WACK.
  - Cycles with reqcyc=0 stall with no effect.
- RWAIT: decrement the counter each cycle; at 0, go to RRESP with beat=0.
- RRESP:
  - respcyc=1, resp=store[base+beat], resptag=latched tag.
  - Beats are in increasing address order.
  - When respack=1, advance beat. Acking beat LINE_BEATS-1 returns to IDLE with respcyc=0 the next cycle.
  - When respack=0, respcyc, resp and resptag hold unchanged.
- WACK: one beat with respcyc=1, resp=0, resptag=tag; held until respack=1, then IDLE.
- Timing: read header accepted at cycle T gives the first respcyc at T+READ_LATENCY+1. With respack tied to respcyc, beats are back-to-back, one per cycle.
- reqcyc in RWAIT/RRESP/WACK: reqack=0; the request is not latched; it is served after return to IDLE.
- Back-to-back: a header may be accepted in the same cycle the FSM enters IDLE (the cycle after the final respack).
- Reset mid-operation: abort immediately.
  - respcyc=0 the following cycle.
  - A partially written line keeps the beats already stored.
- Store read-during-write: not possible (write and read states are exclusive).

Decomposition:
- Package sysbus_pkg:
  - tag field positions and widths.
  - READ/WRITE and MEMORY/MMIO constants.
  - LINE_BEATS and line byte size.
  - responder state enum {IDLE, WDATA, RWAIT, RRESP, WACK}.
- Sub-module sysbus_mem_array: MEM_WORDS x DATA_WIDTH, one synchronous write port, one read port.
  - If the read is synchronous (1 cycle), the responder prefetches beat+1 so resp is valid whenever respcyc=1.
- FSM, counters and tag/address latches live in sysbus_mem_responder.

Test Plan:
- Reset: hold reset=0 3 cycles with reqcyc=1 -> reqack=0 after the release edge only when IDLE; respcyc=0, resp=0, resptag=0 during reset.
- Aligned read: preload store[0x200+i]=0xA0+i; header req=0x1000, tag={READ,MEMORY,8'h05} at T with respack=respcyc -> respcyc first at T+5; resp 0xA0..0xA7 on 8 consecutive cycles; resptag=0x1105; then IDLE.
- Unaligned and wrap: read req=0x1013 -> identical data to 0x1000. Read req=(MEM_WORDS*8+0x1000) -> same data (modulo wrap).
- Backpressure: during the read, respack=0 on beats 2 and 5 for 3 cycles each -> resp/respcyc stable; all 8 values are delivered exactly once in order; total 14 response cycles.
- Write then read: write header 0x2000 plus 8 data beats 0x11..0x88, reqcyc dropped for 2 cycles after beat 3 -> one WACK beat (resp=0, tag echoed). Subsequent read of 0x2000 returns 0x11..0x88.
- Reset mid-burst: reset=0 after beat 3 of a read -> respcyc=0 next cycle; after release a new read is accepted and returns correct data from beat 0.

Source files
------------

// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sysbus_pkg
//  Brief    : Shared Sysbus definitions: tag field layout, R/W and type
//             encodings, line geometry and the responder state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

    // Tag layout: [12] R/W, [11:8] type, [7:0] id
    localparam int SB_TAG_W        = 13;
    localparam int SB_TAG_RW_BIT   = 12;
    localparam int SB_TAG_TYPE_MSB = 11;
    localparam int SB_TAG_TYPE_LSB = 8;
    localparam int SB_TAG_ID_MSB   = 7;
    localparam int SB_TAG_ID_LSB   = 0;

    localparam logic       SB_TAG_READ        = 1'b1;
    localparam logic       SB_TAG_WRITE       = 1'b0;
    localparam logic [3:0] SB_TAG_TYPE_MEMORY = 4'h1;
    localparam logic [3:0] SB_TAG_TYPE_MMIO   = 4'h0;

    // Line geometry: 8 beats of 64 bits = 64-byte line
    localparam int SB_BEAT_BYTES = 8;
    localparam int SB_LINE_BEATS = 8;
    localparam int SB_LINE_BYTES = SB_LINE_BEATS * SB_BEAT_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_RWAIT = 3'd2,
        ST_RRESP = 3'd3,
        ST_WACK  = 3'd4
    } resp_state_t;

    // True when the tag marks a read request
    function automatic logic tag_is_read(input logic [SB_TAG_W-1:0] tag);
        return tag[SB_TAG_RW_BIT] == SB_TAG_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysbus_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : sysbus_mem_array
//  Brief    : Word-addressed backing store, one synchronous write port and
//             one registered read port (data valid the cycle after address).
//  Revision : 1.0 - initial release
// ============================================================================
module sysbus_mem_array #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port: store one word when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered read every cycle
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sysbus_mem_responder
//  Brief    : Memory-side Sysbus responder. Accepts line reads/writes and
//             serves them from an internal backing store; reads return
//             LINE_BEATS beats after READ_LATENCY idle cycles, writes end
//             with a single zero-data acknowledge beat.
//  Revision : 1.0 - initial release
// ============================================================================
module sysbus_mem_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int LINE_BEATS   = 8,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqcyc,
    input  logic [DATA_WIDTH-1:0] req,
    input  logic [TAG_WIDTH-1:0]  reqtag,
    output logic                  reqack,
    output logic                  respcyc,
    output logic [DATA_WIDTH-1:0] resp,
    output logic [TAG_WIDTH-1:0]  resptag,
    input  logic                  respack
);

    import sysbus_pkg::*;

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int BW  = $clog2(LINE_BEATS);
    localparam int CW  = $clog2(READ_LATENCY + 1);
    // Byte offset bits inside one line; these address bits are ignored
    localparam int OFF = $clog2(LINE_BEATS * DATA_WIDTH / 8);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

    resp_state_t           r_state;
    resp_state_t           w_state_next;
    logic [AW-1:0]         r_base;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [BW-1:0]         r_beat;
    logic [CW-1:0]         r_cnt;

    logic [DATA_WIDTH-OFF-1:0] w_line;
    logic [AW-1:0]             w_hdr_base;
    logic                      w_unused_req;
    logic                      w_accepting;
    logic                      w_rd_adv;
    logic [BW-1:0]             w_rd_beat;
    logic [AW-1:0]             w_rd_addr;
    logic [AW-1:0]             w_wr_addr;
    logic                      w_we;
    logic [DATA_WIDTH-1:0]     w_rdata;

    // Line number times LINE_BEATS, wrapped into the store depth
    assign w_line       = req[DATA_WIDTH-1:OFF];
    assign w_hdr_base   = {w_line[AW-BW-1:0], {BW{1'b0}}};
    assign w_unused_req = ^{req[OFF-1:0], w_line[DATA_WIDTH-OFF-1:AW-BW]};

    assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_WDATA);

    // Read address runs one beat ahead on an ack so the registered array
    // output already holds the next beat when it is presented
    assign w_rd_adv  = (r_state == ST_RRESP) && respack;
    assign w_rd_beat = r_beat + BW'(w_rd_adv);
    assign w_rd_addr = r_base + AW'(w_rd_beat);

    assign w_wr_addr = r_base + AW'(r_beat);
    assign w_we      = reset && (r_state == ST_WDATA) && reqcyc;

    sysbus_mem_array #(
        .DEPTH (MEM_WORDS),
        .WIDTH (DATA_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_wr_addr),
        .i_wdata (req),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (reqcyc) begin
                    w_state_next = tag_is_read(reqtag) ? ST_RWAIT : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (reqcyc && (r_beat == LAST_BEAT)) begin
                    w_state_next = ST_WACK;
                end
            end
            ST_RWAIT: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_next = ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (respack && (r_beat == LAST_BEAT)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WACK: begin
                if (respack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Header latches, beat counter and latency counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_base <= '0;
            r_tag  <= '0;
            r_beat <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (reqcyc) begin
                        r_base <= w_hdr_base;
                        r_tag  <= reqtag;
                        r_beat <= '0;
                        r_cnt  <= CW'(READ_LATENCY);
                    end
                end
                ST_WDATA: begin
                    if (reqcyc) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_RWAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RRESP: begin
                    if (respack) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        reqack  = reqcyc && w_accepting;
        respcyc = 1'b0;
        resp    = '0;
        resptag = r_tag;
        case (r_state)
            ST_RRESP: begin
                respcyc = 1'b1;
                resp    = w_rdata;
            end
            ST_WACK: begin
                respcyc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysbus_mem_responder
//  Brief    : Self-checking bench for sysbus_mem_responder: a table of
//             line write/read transactions with expected data, backpressure,
//             address wrap/alignment and mid-transfer reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_mem_responder;

    import sysbus_pkg::*;

    localparam int TB_DW  = 64;
    localparam int TB_TW  = 13;
    localparam int TB_LB  = 8;
    localparam int TB_MW  = 4096;
    localparam int TB_RL  = 4;

    logic              clk     = 1'b0;
    logic              reset   = 1'b0;
    logic              reqcyc  = 1'b0;
    logic [TB_DW-1:0]  req     = '0;
    logic [TB_TW-1:0]  reqtag  = '0;
    logic              respack = 1'b0;
    logic              reqack;
    logic              respcyc;
    logic [TB_DW-1:0]  resp;
    logic [TB_TW-1:0]  resptag;

    int checks = 0;
    int errors = 0;

    sysbus_mem_responder #(
        .DATA_WIDTH   (TB_DW),
        .TAG_WIDTH    (TB_TW),
        .LINE_BEATS   (TB_LB),
        .MEM_WORDS    (TB_MW),
        .READ_LATENCY (TB_RL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqcyc  (reqcyc),
        .req     (req),
        .reqtag  (reqtag),
        .reqack  (reqack),
        .respcyc (respcyc),
        .resp    (resp),
        .resptag (resptag),
        .respack (respack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [7:0]  id;
        logic [3:0]  typ;
        logic [63:0] d0;     // data of beat i is d0 + i*step
        logic [63:0] step;
        logic [7:0]  bp;     // read: stall 3 cycles on these beats
        int          gap;    // write: drop reqcyc 2 cycles after this beat
        logic [7:0]  cm;     // read: beats whose data is checked
        int          abort;  // reset after this many beats (-1: none)
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [63:0] a, input logic [7:0] id,
                                input logic [3:0] t, input logic [63:0] d0, input logic [63:0] st,
                                input logic [7:0] bp, input int gap, input logic [7:0] cm,
                                input int ab);
        vec_t v;
        v.is_wr = w; v.addr = a; v.id = id; v.typ = t; v.d0 = d0; v.step = st;
        v.bp = bp; v.gap = gap; v.cm = cm; v.abort = ab;
        return v;
    endfunction

    // Hold reset low for n edges, checking idle outputs, then release
    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_respcyc", respcyc, 1'b0);
            chk("rst_resp", resp, 64'h0);
            chk("rst_resptag", resptag, 64'h0);
        end
        reqcyc = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
    endtask

    // Present one request beat until accepted; returns wait cycles
    task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int waits);
        reqcyc = 1'b1;
        req    = d;
        reqtag = t;
        waits  = 0;
        @(negedge clk);
        while (!reqack && waits < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            waits++;
        end
        if (!reqack) chk("reqack_timeout", reqack, 1'b1);
        @(posedge clk); #1;
        reqcyc = 1'b0;
    endtask

    task automatic do_write(input vec_t v);
        logic [12:0] tag;
        int w;
        int n;
        tag = {SB_TAG_WRITE, v.typ, v.id};
        send_beat(v.addr, tag, w);
        chk("wr_hdr_wait", w, 0);
        for (int i = 0; i < TB_LB; i++) begin
            if (i == v.abort) break;
            send_beat(v.d0 + i * v.step, tag, w);
            chk("wr_data_wait", w, 0);
            if (i == v.gap) begin
                repeat (2) begin
                    @(negedge clk);
                    chk("wr_gap_respcyc", respcyc, 1'b0);
                    @(posedge clk); #1;
                end
            end
        end
        if (v.abort >= 0) begin
            do_reset(1);
            return;
        end
        n = 0;
        @(negedge clk);
        while (!respcyc && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("wack_delay", n, 0);
        chk("wack_respcyc", respcyc, 1'b1);
        chk("wack_resp", resp, 64'h0);
        chk("wack_tag", resptag, tag);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wack_hold", respcyc, 1'b1);
        respack = 1'b1;
        @(posedge clk); #1;
        respack = 1'b0;
        @(negedge clk);
        chk("wack_done", respcyc, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input vec_t v);
        logic [12:0] tag;
        int w;
        int n;
        int beat;
        int cyc;
        int st;
        tag = {SB_TAG_READ, v.typ, v.id};
        send_beat(v.addr, tag, w);
        chk("rd_hdr_wait", w, 0);
        n = 1;
        @(negedge clk);
        while (!respcyc && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("rd_latency", n, TB_RL + 1);
        beat = 0; cyc = 0; st = 0;
        while (beat < TB_LB && cyc < 100) begin
            if (beat == v.abort) break;
            if (!respcyc) begin
                chk("rd_respcyc", respcyc, 1'b1);
                break;
            end
            if (v.cm[beat]) chk($sformatf("rd_data[%0d]", beat), resp, v.d0 + beat * v.step);
            chk("rd_tag", resptag, tag);
            if (v.bp[beat] && st < 3) begin
                respack = 1'b0;
                st++;
            end else begin
                respack = 1'b1;
                beat++;
                st = 0;
            end
            cyc++;
            @(posedge clk); #1;
            respack = 1'b0;
            @(negedge clk);
        end
        if (v.abort >= 0) begin
            reset = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_respcyc", respcyc, 1'b0);
            chk("abort_resp", resp, 64'h0);
            reset = 1'b1;
            @(posedge clk); #1;
            return;
        end
        chk("rd_cycles", cyc, TB_LB + 3 * $countones(v.bp));
        chk("rd_end", respcyc, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending request on the bus
        reset  = 1'b0;
        reqcyc = 1'b1;
        req    = 64'h1000;
        reqtag = {SB_TAG_READ, SB_TAG_TYPE_MEMORY, 8'h55};
        do_reset(3);

        //         wr    addr                    id     typ                 d0      step    bp     gap cm     abort
        vecs[0]  = mk(1, 64'h1000,               8'h01, SB_TAG_TYPE_MEMORY, 64'hA0, 64'h01, 8'h00, -1, 8'hFF, -1);
        vecs[1]  = mk(0, 64'h1000,               8'h05, SB_TAG_TYPE_MEMORY, 64'hA0, 64'h01, 8'h00, -1, 8'hFF, -1);
        vecs[2]  = mk(0, 64'h1013,               8'h06, SB_TAG_TYPE_MMIO,   64'hA0, 64'h01, 8'h00, -1, 8'hFF, -1);
        vecs[3]  = mk(0, 64'h9000,               8'h07, SB_TAG_TYPE_MEMORY, 64'hA0, 64'h01, 8'h00, -1, 8'hFF, -1);
        vecs[4]  = mk(0, 64'hFFFF_FFFF_FFFF_1000, 8'h08, SB_TAG_TYPE_MEMORY, 64'hA0, 64'h01, 8'h00, -1, 8'hFF, -1);
        vecs[5]  = mk(0, 64'h1000,               8'h09, SB_TAG_TYPE_MEMORY, 64'hA0, 64'h01, 8'h24, -1, 8'hFF, -1);
        vecs[6]  = mk(1, 64'h2000,               8'h20, SB_TAG_TYPE_MEMORY, 64'h11, 64'h11, 8'h00,  3, 8'hFF, -1);
        vecs[7]  = mk(0, 64'h2000,               8'h21, SB_TAG_TYPE_MEMORY, 64'h11, 64'h11, 8'h00, -1, 8'hFF,  4);
        vecs[8]  = mk(0, 64'h2000,               8'h22, SB_TAG_TYPE_MEMORY, 64'h11, 64'h11, 8'h00, -1, 8'hFF, -1);
        vecs[9]  = mk(1, 64'h3000,               8'h30, SB_TAG_TYPE_MEMORY, 64'hC0, 64'h01, 8'h00, -1, 8'hFF,  3);
        vecs[10] = mk(0, 64'h3000,               8'h31, SB_TAG_TYPE_MEMORY, 64'hC0, 64'h01, 8'h00, -1, 8'h07, -1);

        for (int k = 0; k < 11; k++) begin
            if (vecs[k].is_wr) do_write(vecs[k]);
            else               do_read(vecs[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
